// File: rtl/interp_pkg.sv
// rtl/interp_pkg.sv - shared defaults, sample table and result type for the interpolator
//
// Purpose: default widths, the derived index width, the 16-entry sample table
// used by the constant ROM, and the result typedef.
// Ports: none (package).
// Configuration: the table is only used when INTERP_LUT_WRITE_EN is undefined.
package interp_pkg;

  localparam int DATA_W_DEF      = 8;
  localparam int FRAC_BITS_DEF   = 4;
  localparam int IDX_W_DEF       = DATA_W_DEF - FRAC_BITS_DEF;
  localparam int TABLE_DEPTH_DEF = 1 << IDX_W_DEF;

  typedef logic [DATA_W_DEF-1:0] result_t;

  // Sigmoid-like curve with a deliberate dip at entries 5..6 so that a
  // decreasing segment exists in the default build.
  localparam result_t DEFAULT_TABLE [TABLE_DEPTH_DEF] = '{
    8'd0,   8'd10,  8'd32,  8'd64,  8'd90,  8'd100, 8'd60,  8'd80,
    8'd110, 8'd140, 8'd160, 8'd175, 8'd185, 8'd192, 8'd197, 8'd200
  };

endpackage

// File: rtl/interp_lut.sv
// rtl/interp_lut.sv - interpolation table with two combinational read ports
//
// Purpose: returns table[idx] and table[idx+1], the second clamped to the
// last entry so the top segment never wraps to entry 0.
// Ports:
//   clk_i, we_i, waddr_i, wdata_i  write port (only with INTERP_LUT_WRITE_EN)
//   rd_idx_i                       segment index
//   base_o, next_o                 table[idx], table[min(idx+1, last)]
// Configuration: INTERP_LUT_WRITE_EN selects a writable register array,
// otherwise a constant ROM filled from interp_pkg::DEFAULT_TABLE.
module interp_lut
  import interp_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IDX_W  = IDX_W_DEF
) (
`ifdef INTERP_LUT_WRITE_EN
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
`endif
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic [DATA_W-1:0] base_o,
  output logic [DATA_W-1:0] next_o
);

  localparam int DEPTH = 1 << IDX_W;

  logic [IDX_W-1:0] nxt_idx;

  assign nxt_idx = (rd_idx_i == {IDX_W{1'b1}}) ? rd_idx_i : rd_idx_i + IDX_W'(1);

`ifdef INTERP_LUT_WRITE_EN
  // No reset: table contents survive rst. Reads see the pre-edge value, so a
  // same-cycle write and read of one entry returns the old data.
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign base_o = mem_q[rd_idx_i];
  assign next_o = mem_q[nxt_idx];
`else
  // Entries beyond the packaged table (non-default widths) read as zero.
  function automatic logic [DATA_W-1:0] rom_entry(input logic [IDX_W-1:0] idx);
    int i;
    i = int'(idx);
    if (i < TABLE_DEPTH_DEF) begin
      return DATA_W'(DEFAULT_TABLE[i]);
    end
    return '0;
  endfunction

  assign base_o = rom_entry(rd_idx_i);
  assign next_o = rom_entry(nxt_idx);
`endif

endmodule

// File: rtl/pipelined_interpolator.sv
// rtl/pipelined_interpolator.sv - three-stage table-lookup linear interpolator
//
// Purpose: splits in_z into segment index and fraction, looks up the two
// segment endpoints and returns base + floor((next-base)*frac / 2^FRAC_BITS).
// Ports:
//   clk, rst (sync, active high)
//   in_valid/in_ready/in_z/in_id       sample input with channel tag
//   out_valid/out_ready/out_value/out_id  result output with tag
//   lut_we/lut_addr/lut_wdata           table write (only with INTERP_LUT_WRITE_EN)
// Configuration: INTERP_LUT_WRITE_EN makes the table writable.
module pipelined_interpolator
  import interp_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int FRAC_BITS = FRAC_BITS_DEF,
  parameter int ID_W      = 4
) (
  input  logic                        clk,
  input  logic                        rst,
`ifdef INTERP_LUT_WRITE_EN
  input  logic                        lut_we,
  input  logic [DATA_W-FRAC_BITS-1:0] lut_addr,
  input  logic [DATA_W-1:0]           lut_wdata,
`endif
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_z,
  input  logic [ID_W-1:0]             in_id,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_value,
  output logic [ID_W-1:0]             out_id
);

  localparam int IDX_W  = DATA_W - FRAC_BITS;
  // Wide enough for (DATA_W+1)-bit signed diff times unsigned frac.
  localparam int PROD_W = DATA_W + FRAC_BITS + 2;

  logic advance;

  logic                 s1_valid_q;
  logic [IDX_W-1:0]     s1_idx_q;
  logic [FRAC_BITS-1:0] s1_frac_q;
  logic [ID_W-1:0]      s1_id_q;

  logic                 s2_valid_q;
  logic [DATA_W-1:0]    s2_base_q;
  logic [DATA_W-1:0]    s2_next_q;
  logic [FRAC_BITS-1:0] s2_frac_q;
  logic [ID_W-1:0]      s2_id_q;

  logic                 out_valid_q;
  logic [DATA_W-1:0]    out_value_q;
  logic [ID_W-1:0]      out_id_q;

  logic [DATA_W-1:0]    lut_base;
  logic [DATA_W-1:0]    lut_next;

  logic signed [DATA_W:0]   diff;
  logic signed [PROD_W-1:0] diff_x;
  logic signed [PROD_W-1:0] frac_x;
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] sum;
  logic [DATA_W-1:0]        out_value_d;

  // One global stall: every stage moves only when the output slot frees up,
  // so bubbles stay in place and ordering is trivially preserved.
  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;

  interp_lut #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_lut (
`ifdef INTERP_LUT_WRITE_EN
    .clk_i    (clk),
    .we_i     (lut_we),
    .waddr_i  (lut_addr),
    .wdata_i  (lut_wdata),
`endif
    .rd_idx_i (s1_idx_q),
    .base_o   (lut_base),
    .next_o   (lut_next)
  );

  // Multiply before shifting so the arithmetic shift floors the exact product.
  always_comb begin
    diff        = $signed({1'b0, s2_next_q}) - $signed({1'b0, s2_base_q});
    diff_x      = PROD_W'(diff);
    frac_x      = PROD_W'($signed({1'b0, s2_frac_q}));
    prod        = diff_x * frac_x;
    sum         = PROD_W'($signed({1'b0, s2_base_q})) + (prod >>> FRAC_BITS);
    out_value_d = DATA_W'(sum);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_idx_q    <= '0;
      s1_frac_q   <= '0;
      s1_id_q     <= '0;
      s2_valid_q  <= 1'b0;
      s2_base_q   <= '0;
      s2_next_q   <= '0;
      s2_frac_q   <= '0;
      s2_id_q     <= '0;
      out_valid_q <= 1'b0;
      out_value_q <= '0;
      out_id_q    <= '0;
    end else if (advance) begin
      s1_valid_q  <= in_valid;
      s1_idx_q    <= in_z[DATA_W-1:FRAC_BITS];
      s1_frac_q   <= in_z[FRAC_BITS-1:0];
      s1_id_q     <= in_id;
      s2_valid_q  <= s1_valid_q;
      s2_base_q   <= lut_base;
      s2_next_q   <= lut_next;
      s2_frac_q   <= s1_frac_q;
      s2_id_q     <= s1_id_q;
      out_valid_q <= s2_valid_q;
      out_value_q <= out_value_d;
      out_id_q    <= s2_id_q;
    end
  end

  assign out_valid = out_valid_q;
  assign out_value = out_value_q;
  assign out_id    = out_id_q;

endmodule

// File: tb/tb_pipelined_interpolator.sv
// tb/tb_pipelined_interpolator.sv - scoreboard bench for pipelined_interpolator
module tb_pipelined_interpolator;
  import interp_pkg::*;

  localparam int DW = 8;
  localparam int FB = 4;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_z = '0;
  logic [IW-1:0] in_id = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_value;
  logic [IW-1:0] out_id;
`ifdef INTERP_LUT_WRITE_EN
  logic             lut_we = 1'b0;
  logic [DW-FB-1:0] lut_addr = '0;
  logic [DW-1:0]    lut_wdata = '0;
`endif

  pipelined_interpolator #(
    .DATA_W    (DW),
    .FRAC_BITS (FB),
    .ID_W      (IW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef INTERP_LUT_WRITE_EN
    .lut_we    (lut_we),
    .lut_addr  (lut_addr),
    .lut_wdata (lut_wdata),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_z      (in_z),
    .in_id     (in_id),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_value (out_value),
    .out_id    (out_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    result_t       value;
    logic [IW-1:0] id;
    int            acc_cyc;
    bit            chk_lat;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance
  // with in_valid still high so consecutive calls stream back-to-back.
  task automatic send(input logic [7:0] z, input logic [3:0] id,
                      input logic [7:0] exp, input bit lat);
    exp_t e;
    in_valid = 1'b1;
    in_z     = z;
    in_id    = id;
    for (int w = 0; w < 50; w++) begin
      #1;
      if (in_ready === 1'b1) begin
        e.value   = exp;
        e.id      = id;
        e.acc_cyc = cyc;
        e.chk_lat = lat;
        sb.push_back(e);
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    chk("send_timeout", 1, 0);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Monitor: samples 2 time units after the falling edge.
  exp_t          mon_e;
  bit            stalled_prev = 1'b0;
  result_t       held_v;
  logic [IW-1:0] held_id;

  always @(negedge clk) begin
    #2;
    if (rst) begin
      stalled_prev = 1'b0;
    end else if (out_valid === 1'b1) begin
      if (stalled_prev) begin
        chk("stall_value_stable", out_value, held_v);
        chk("stall_id_stable", out_id, held_id);
      end
      if (out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("out_value", out_value, mon_e.value);
          chk("out_id", out_id, mon_e.id);
          if (mon_e.chk_lat) chk("latency", cyc - mon_e.acc_cyc, 3);
        end
        stalled_prev = 1'b0;
      end else begin
        chk("in_ready_low_when_stalled", in_ready, 0);
        stalled_prev = 1'b1;
        held_v       = out_value;
        held_id      = out_id;
      end
    end else begin
      if (stalled_prev) chk("stalled_output_dropped", 0, 1);
      stalled_prev = 1'b0;
    end
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #3;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_value", out_value, 0);
    chk("reset_out_id", out_id, 0);
    chk("reset_in_ready", in_ready, 1);
    @(negedge clk);

`ifdef INTERP_LUT_WRITE_EN
    for (int i = 0; i < TABLE_DEPTH_DEF; i++) begin
      lut_we    = 1'b1;
      lut_addr  = 4'(i);
      lut_wdata = DEFAULT_TABLE[i];
      @(negedge clk);
    end
    lut_we = 1'b0;
`endif

    // Single samples with latency checks: 32 + floor(32*8/16) = 48.
    send(8'h28, 4'd1, 8'd48, 1'b1);
    idle(5);
    // Back-to-back: decreasing segment 100 + floor(-40*12/16) = 70,
    // last-index clamp 0xFF and 0xF0 -> 200, frac 0 at 0x50 -> 100.
    send(8'h5C, 4'd2, 8'd70, 1'b1);
    send(8'hFF, 4'd3, 8'd200, 1'b1);
    send(8'hF0, 4'd4, 8'd200, 1'b1);
    send(8'h50, 4'd5, 8'd100, 1'b1);
    idle(6);

    // 8-sample stream with a 5-cycle downstream stall in the middle.
    fork
      begin
        send(8'h00, 4'd0, 8'd0,   1'b0);
        send(8'h18, 4'd1, 8'd21,  1'b0);
        send(8'h34, 4'd2, 8'd70,  1'b0);
        send(8'h68, 4'd3, 8'd70,  1'b0);
        send(8'h73, 4'd4, 8'd85,  1'b0);
        send(8'h9A, 4'd5, 8'd152, 1'b0);
        send(8'hE1, 4'd6, 8'd197, 1'b0);
        send(8'h57, 4'd7, 8'd82,  1'b0);
      end
      begin
        repeat (4) @(negedge clk);
        out_ready = 1'b0;
        repeat (5) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    idle(10);

    // Reset with three samples in flight: none of them may ever appear.
    out_ready = 1'b0;
    send(8'h10, 4'd8,  8'd10, 1'b0);
    send(8'h20, 4'd9,  8'd32, 1'b0);
    send(8'h30, 4'd10, 8'd64, 1'b0);
    in_valid = 1'b0;
    rst      = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    #3;
    chk("post_reset_out_valid", out_valid, 0);
    chk("post_reset_in_ready", in_ready, 1);
    out_ready = 1'b1;
    idle(8);

`ifdef INTERP_LUT_WRITE_EN
    // Write entry 2 on the edge where the in-flight sample reads it.
    send(8'h20, 4'd11, 8'd32, 1'b0);
    in_valid  = 1'b0;
    lut_we    = 1'b1;
    lut_addr  = 4'd2;
    lut_wdata = 8'd96;
    @(negedge clk);
    lut_we = 1'b0;
    send(8'h20, 4'd12, 8'd96, 1'b0);
    idle(6);
`endif

    for (int w = 0; w < 100 && sb.size() != 0; w++) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
